uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_sched_arb.sv | 30 +++
 rtl/uart_tx_sched.sv | 101 ++++++++++
 tb/tb_uart_tx_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

    // Serial frame: start + 8 data + parity + 2 stop = 12 bits, padded to 13 slots.
    localparam int BIT_CLKS       = 6;
    localparam int FRAME_BITS     = 13;
    localparam int FRAME_CLKS_DEF = BIT_CLKS * FRAME_BITS + 2;

    // Width of the frame timer; frame plus gap must fit below 2**TMR_W.
    localparam int TMR_W = 16;

    // Scheduler states, kept as plain constants for compatibility with older blocks.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_LOAD = 2'd1;
    localparam sched_state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] win,
    output logic          vld
);

    int idx;

    // Scan from the farthest slot back to ptr so the slot closest to ptr wins last.
    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                win = IW'(idx);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter; times each frame itself
// because the transmitter has no busy output.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N          = 4,
    parameter int FRAME_CLKS = FRAME_CLKS_DEF,
    parameter int GAP_CLKS   = 0
) (
    input  logic                 c,
    input  logic                 r,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [8*N-1:0]       din_bus,
    output logic [N-1:0]         ack,
    output logic                 ee,
    output logic [7:0]           tx_din,
    output logic [$clog2(N)-1:0] cur_id,
    output logic                 busy,
    output logic                 done
);

    localparam int IW        = $clog2(N);
    localparam int WAIT_CLKS = FRAME_CLKS - 2 + GAP_CLKS;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WAIT_CLKS - 1);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("uart_tx_sched: N must be in 2..8");
    end
    if (FRAME_CLKS < 3) begin : g_bad_frame
        $error("uart_tx_sched: FRAME_CLKS must be at least 3");
    end
    if (FRAME_CLKS + GAP_CLKS >= (1 << TMR_W)) begin : g_bad_tmr
        $error("uart_tx_sched: FRAME_CLKS + GAP_CLKS does not fit the frame timer");
    end

    sched_state_t     state;
    logic [IW-1:0]    ptr;
    logic [TMR_W-1:0] tmr;
    logic [IW-1:0]    win;
    logic             win_vld;
    logic [IW-1:0]    ptr_nxt;

    uart_rr_arb #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win),
        .vld (win_vld)
    );

    // Just-served requester drops to lowest priority on the next search.
    assign ptr_nxt = (win == IW'(N - 1)) ? '0 : win + 1'b1;

    // Grant, strobe, frame timing; reset aborts any frame without a done pulse.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            tmr    <= '0;
            tx_din <= 8'h00;
            cur_id <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && win_vld) begin
                        tx_din <= din_bus[{win, 3'b000} +: 8];
                        cur_id <= win;
                        ptr    <= ptr_nxt;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tmr   <= TMR_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobe, acknowledge and busy are pure state decodes, so req never reaches an output.
    always_comb begin
        ee   = (state == ST_LOAD);
        ack  = ee ? (N'(1) << cur_id) : '0;
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: scoreboarded grants plus directed timing checks.
module tb_uart_tx_sched;

    logic       c = 1'b0;
    logic       r;
    logic       en;
    logic [3:0] req;
    logic [3:0] reqg;
    logic [31:0] din;

    logic [3:0] ack0, ack1;
    logic       ee0, ee1, busy0, busy1, done0, done1;
    logic [7:0] tx0, tx1;
    logic [1:0] id0, id1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_ee = 0, last_ee = 0, n_done = 0, last_done = 0;
    int g_n = 0, g_done_n = 0;
    int g_ee[4];
    int g_id[4];
    int g_done[4];

    uart_tx_sched #(.N(4), .FRAME_CLKS(80), .GAP_CLKS(0)) u_dut (
        .c(c), .r(r), .en(en), .req(req), .din_bus(din),
        .ack(ack0), .ee(ee0), .tx_din(tx0), .cur_id(id0), .busy(busy0), .done(done0)
    );

    uart_tx_sched #(.N(4), .FRAME_CLKS(80), .GAP_CLKS(20)) u_gap (
        .c(c), .r(r), .en(en), .req(reqg), .din_bus(din),
        .ack(ack1), .ee(ee1), .tx_din(tx1), .cur_id(id1), .busy(busy1), .done(done1)
    );

    always #5 c = ~c;

    always @(posedge c) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Every strobe must match the next expected grant in order.
    always @(negedge c) begin
        if (ee0 || ack0 != 4'b0000) begin
            chk("ack_with_ee", 32'(ee0), 1);
            chk("grant_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("ack", 32'(ack0), 32'(1) << exp_q[0].id);
                chk("cur_id", 32'(id0), exp_q[0].id);
                chk("tx_din", 32'(tx0), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            n_ee    <= n_ee + 1;
            last_ee <= cyc;
        end
        if (done0) begin
            n_done    <= n_done + 1;
            last_done <= cyc;
        end
    end

    // Record strobe/done times of the gapped instance.
    always @(negedge c) begin
        if (ee1) begin
            if (g_n < 4) begin
                g_ee[g_n] <= cyc;
                g_id[g_n] <= int'(id1);
            end
            g_n <= g_n + 1;
        end
        if (done1) begin
            if (g_done_n < 4) g_done[g_done_n] <= cyc;
            g_done_n <= g_done_n + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge c);
            #1;
        end
    endtask

    task automatic push(input int id);
        exp_q.push_back('{id, din[8*id +: 8]});
    endtask

    task automatic wait_ee(input int bound);
        int start;
        int k;
        start = n_ee;
        k = 0;
        while (n_ee == start && k < bound) begin
            tick();
            k++;
        end
        chk("ee_seen", 32'(n_ee != start), 1);
    endtask

    task automatic wait_done(input int bound);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < bound) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(n_done != start), 1);
    endtask

    task automatic do_reset();
        r = 1'b1;
        tick(2);
        r = 1'b0;
    endtask

    initial begin
        int t0;
        int prev;
        int nb;
        int nd;
        int k;

        r    = 1'b1;
        en   = 1'b1;
        req  = 4'b0000;
        reqg = 4'b0000;
        din  = 32'h3CA55A96;

        // Reset values
        tick(3);
        chk("rst_ack", 32'(ack0), 0);
        chk("rst_ee", 32'(ee0), 0);
        chk("rst_tx_din", 32'(tx0), 0);
        chk("rst_cur_id", 32'(id0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        r = 1'b0;
        tick(2);

        // Single request from requester 2
        req = 4'b0100;
        push(2);
        t0 = cyc;
        wait_ee(5);
        chk("single_lat", last_ee - t0, 1);
        req = 4'b0000;
        tick(78);
        chk("single_busy_end", 32'(busy0), 1);
        chk("single_no_early_done", 32'(done0), 0);
        wait_done(5);
        chk("single_done_lat", last_done - last_ee, 79);
        chk("single_idle", 32'(busy0), 0);

        // All four requesting: order 0,1,2,3,0 with fixed spacing
        do_reset();
        req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        t0 = cyc;
        wait_ee(5);
        chk("rr_first_lat", last_ee - t0, 1);
        prev = last_ee;
        for (int i = 1; i < 5; i++) begin
            wait_ee(100);
            chk("rr_spacing", last_ee - prev, 80);
            prev = last_ee;
        end
        req = 4'b0000;
        wait_done(100);
        chk("rr_done_lat", last_done - last_ee, 79);
        tick(5);
        chk("rr_drained", exp_q.size(), 0);

        // Reset in the middle of WAIT, requester 3 keeps holding
        req = 4'b1000;
        push(3);
        push(3);
        wait_ee(5);
        tick(30);
        nd = n_done;
        r = 1'b1;
        #1;
        chk("midrst_ack", 32'(ack0), 0);
        chk("midrst_ee", 32'(ee0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_tx_din", 32'(tx0), 0);
        chk("midrst_cur_id", 32'(id0), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_done", 32'(done0), 0);
        end
        r = 1'b0;
        t0 = cyc;
        wait_ee(5);
        chk("midrst_regrant_lat", last_ee - t0, 1);
        chk("midrst_no_done", n_done - nd, 0);
        req = 4'b0000;
        wait_done(100);

        // en low blocks the pending grant but not the frame in flight
        req = 4'b0001;
        push(0);
        wait_ee(5);
        req = 4'b0010;
        en  = 1'b0;
        push(1);
        nb = n_ee;
        tick(10);
        en = 1'b1;
        tick(5);
        en = 1'b0;
        wait_done(100);
        chk("en0_done_lat", last_done - last_ee, 79);
        tick(10);
        chk("en0_no_grant", n_ee - nb, 0);
        chk("en0_idle", 32'(busy0), 0);
        en = 1'b1;
        t0 = cyc;
        wait_ee(3);
        chk("en_rise_lat", last_ee - t0, 1);
        req = 4'b0000;
        wait_done(100);

        // Request raised and withdrawn during WAIT is never served
        req = 4'b0001;
        push(0);
        wait_ee(5);
        req = 4'b0000;
        tick(5);
        req = 4'b0010;
        tick(20);
        req = 4'b0000;
        nb = n_ee;
        wait_done(100);
        tick(10);
        chk("withdraw_no_grant", n_ee - nb, 0);
        chk("withdraw_busy", 32'(busy0), 0);
        chk("withdraw_ee", 32'(ee0), 0);

        // Gapped instance: two requesters, 100-cycle strobe spacing
        reqg = 4'b0011;
        k = 0;
        while (g_n < 2 && k < 400) begin
            tick();
            k++;
        end
        reqg = 4'b0000;
        chk("gap_two_grants", 32'(g_n >= 2), 1);
        chk("gap_spacing", g_ee[1] - g_ee[0], 100);
        chk("gap_first_id", g_id[0], 0);
        chk("gap_second_id", g_id[1], 1);
        chk("gap_done_lat", g_done[0] - g_ee[0], 99);
        tick(110);
        chk("gap_idle", 32'(busy1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
